// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: single-clock FIFO controller that sequences an external
// dual-port RAM (registered read port) as FIFO storage. This block owns
// the pointers, the occupancy count, the status flags and the error pulses.
// Read data returns from the RAM one cycle after an accepted pop.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 512,
  parameter int ADDR_WIDTH   = 9,
  parameter int AFULL_LEVEL  = 496,
  parameter int AEMPTY_LEVEL = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic                  udf,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  // Sized constants so every compare and increment is width-matched.
  localparam logic [ADDR_WIDTH:0]   DEPTH_C    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_C    = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_C   = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE_C  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO_C = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO_C = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST_C = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  full_r;
  logic                  empty_r;
  logic                  afull_r;
  logic                  aempty_r;
  logic                  dout_valid_r;
  logic                  ovf_r;
  logic                  udf_r;

  logic                  push_acc_s;
  logic                  pop_acc_s;
  logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
  logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;

  // Acceptance uses the current flags only: no bypass between push and pop.
  assign push_acc_s = push & ~full_r;
  assign pop_acc_s  = pop  & ~empty_r;

  // RAM ports are driven straight from the current pointers.
  assign ram_wr_en   = push_acc_s;
  assign ram_wr_addr = wr_ptr_r;
  assign ram_wr_data = push_data;
  assign ram_rd_en   = pop_acc_s;
  assign ram_rd_addr = rd_ptr_r;

  // The RAM read register holds between pops, so dout needs no local copy.
  assign dout         = ram_rd_data;
  assign dout_valid   = dout_valid_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign count        = count_r;
  assign ovf          = ovf_r;
  assign udf          = udf_r;

  // Next write pointer: explicit wrap at DEPTH-1 so DEPTH need not be 2^n.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    if (push_acc_s) begin
      if (wr_ptr_r == PTR_LAST_C) begin
        wr_ptr_nxt_s = PTR_ZERO_C;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE_C;
      end
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
  end

  // Next read pointer: same explicit wrap as the write side.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    if (pop_acc_s) begin
      if (rd_ptr_r == PTR_LAST_C) begin
        rd_ptr_nxt_s = PTR_ZERO_C;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE_C;
      end
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Next occupancy: simultaneous accepted push and pop cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_acc_s, pop_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE_C;
      2'b01:   count_nxt_s = count_r - CNT_ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // State and status registers; flags come from next-state count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= PTR_ZERO_C;
      rd_ptr_r     <= PTR_ZERO_C;
      count_r      <= CNT_ZERO_C;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      afull_r      <= 1'b0;
      aempty_r     <= 1'b1;
      dout_valid_r <= 1'b0;
      ovf_r        <= 1'b0;
      udf_r        <= 1'b0;
    end else begin
      wr_ptr_r     <= wr_ptr_nxt_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      count_r      <= count_nxt_s;
      full_r       <= (count_nxt_s == DEPTH_C);
      empty_r      <= (count_nxt_s == CNT_ZERO_C);
      afull_r      <= (count_nxt_s >= AFULL_C);
      aempty_r     <= (count_nxt_s <= AEMPTY_C);
      dout_valid_r <= pop_acc_s;
      ovf_r        <= push & full_r;
      udf_r        <= pop & empty_r;
    end
  end

endmodule
